counter_arb_ctrl: RTL and testbench

//  Shares one N-bit enable/overflow counter between R requesters. Round-robin

---
 rtl/counter_arb_ctrl.sv | 129 ++++++++++++
 tb/tb_counter_arb_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/counter_arb_ctrl.sv
// counter_arb_ctrl: round-robin arbiter lending one shared enable/overflow counter
// to R requesters for a per-request number of overflow periods.
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   req      level requests, held until done or abort
//   cycles   overflow periods wanted, sampled at grant (0 means 2**CYC_W)
//   ov       shared counter overflow pulse
//   cnt_rst  synchronous clear to the shared counter
//   cnt_ce   count enable to the shared counter
//   gnt      one-hot grant
//   done     one-hot completion pulse
//   busy     arbiter not idle
//   err      sticky watchdog flag
// Define COUNTER_ARB_WDOG_EN to add the missing-overflow watchdog; otherwise err is 0.
module counter_arb_ctrl #(
   parameter int N     = 3,
   parameter int R     = 4,
   parameter int CYC_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [R-1:0]     req,
   input  logic [CYC_W-1:0] cycles,
   input  logic             ov,
   output logic             cnt_rst,
   output logic             cnt_ce,
   output logic [R-1:0]     gnt,
   output logic [R-1:0]     done,
   output logic             busy,
   output logic             err
);
   localparam int IW = $clog2(R);
   localparam int RW = CYC_W + 1;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t        state;
   logic [IW-1:0] ptr, win, pick, nxt, idx;
   logic [RW-1:0] remain;
   logic          wd_trip;

   if (R < 2 || N < 1) begin : g_param_check
      $error("counter_arb_ctrl: need R >= 2 and N >= 1");
   end

   // Scanning downward lets the lowest offset from the pointer win.
   always_comb begin
      pick = ptr;
      idx  = '0;
      for (int i = R - 1; i >= 0; i--) begin
         idx = IW'((int'(ptr) + i) % R);
         if (req[idx]) pick = idx;
      end
   end

   assign nxt = (win == IW'(R - 1)) ? '0 : win + 1'b1;

`ifdef COUNTER_ARB_WDOG_EN
   logic [N:0] wd;
   // Trips on the 2**(N+1)-th consecutive RUN clock without an overflow.
   assign wd_trip = (state == RUN) && !ov && (&wd);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd  <= '0;
         err <= 1'b0;
      end else begin
         wd  <= (state == RUN && !ov) ? wd + 1'b1 : '0;
         err <= err | wd_trip;
      end
   end
`else
   assign wd_trip = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         gnt     <= '0;
         done    <= '0;
         cnt_rst <= 1'b1;
         cnt_ce  <= 1'b0;
         busy    <= 1'b0;
         ptr     <= '0;
         win     <= '0;
         remain  <= '0;
      end else begin
         done <= '0;
         case (state)
            IDLE: if (|req) begin
               state  <= CLEAR;
               win    <= pick;
               gnt    <= R'(1) << pick;
               remain <= (cycles == '0) ? RW'(1) << CYC_W : {1'b0, cycles};
               busy   <= 1'b1;
            end
            CLEAR, RUN: begin
               // A dropped request beats a coincident final overflow.
               if (!req[win] || wd_trip) begin
                  state   <= IDLE;
                  gnt     <= '0;
                  cnt_ce  <= 1'b0;
                  cnt_rst <= 1'b1;
                  busy    <= 1'b0;
                  ptr     <= nxt;
               end else if (state == CLEAR) begin
                  state   <= RUN;
                  cnt_rst <= 1'b0;
                  cnt_ce  <= 1'b1;
               end else if (ov && remain == RW'(1)) begin
                  state   <= DONE;
                  done    <= R'(1) << win;
                  gnt     <= '0;
                  cnt_ce  <= 1'b0;
                  cnt_rst <= 1'b1;
                  ptr     <= nxt;
               end else if (ov) begin
                  remain <= remain - RW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_counter_arb_ctrl.sv
// tb_counter_arb_ctrl: scoreboard bench for counter_arb_ctrl with a shared-counter model.
module tb_counter_arb_ctrl;
   typedef struct {
      int win;
      int len;
      bit ab;
   } exp_t;

   logic       clk = 0;
   logic       rst = 0;
   logic [3:0] req = '0;
   logic [3:0] cycles = '0;
   logic       ov;
   logic       cnt_rst, cnt_ce, busy, err;
   logic [3:0] gnt, done;
   logic [2:0] cnt;
   bit         ov_kill = 0;
   bit         model_err = 0;
   int         ptr = 0;
   int         cmp = 0;
   int         bad = 0;
   exp_t       sb[$];

   counter_arb_ctrl #(.N(3), .R(4), .CYC_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .cycles(cycles), .ov(ov),
      .cnt_rst(cnt_rst), .cnt_ce(cnt_ce), .gnt(gnt), .done(done),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) cnt <= cnt_rst ? 3'd0 : cnt_ce ? cnt + 3'd1 : cnt;
   assign ov = !ov_kill && cnt_ce && cnt == 3'd7;

   task automatic check(input string name, input int act, input int exp);
      cmp++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] m, input int p);
      for (int i = 0; i < 4; i++)
         if (m[(p + i) % 4]) return (p + i) % 4;
      return -1;
   endfunction

   int   ce_n = 0;
   logic [3:0] pg = '0;
   bit   pd = 0;
   exp_t me;

   always @(negedge clk) begin
      if (!rst) begin
         pg   = '0;
         pd   = 0;
         ce_n = 0;
      end else begin
         if (pd) check("busy_after_done", busy, 0);
         if (gnt != 0 && pg == 0) begin
            ce_n = 0;
            if (sb.size() == 0) begin
               cmp++;
               bad++;
               $display("FAIL unexpected_grant: gnt=%b with nothing expected", gnt);
            end else check("grant", gnt, 1 << sb[0].win);
            check("clear_phase", {cnt_rst, cnt_ce}, 2);
         end
         if (cnt_ce) ce_n++;
         if (done != 0 || (gnt == 0 && pg != 0)) begin
            if (sb.size() == 0) begin
               cmp++;
               bad++;
               $display("FAIL unexpected_end: done=%b with nothing expected", done);
            end else begin
               me = sb.pop_front();
               check("done", done, me.ab ? 0 : 1 << me.win);
               check("run_clks", ce_n, me.len);
               check("err", err, model_err);
            end
         end
         pd = done != 0;
         pg = gnt;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_cnt_ce"}, cnt_ce, 0);
      check({tag, "_cnt_rst"}, cnt_rst, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err, 0);
   endtask

   task automatic do_reset();
      rst = 0;
      req = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      sb.delete();
      ptr = 0;
      model_err = 0;
      rst = 1;
   endtask

   // k < 0: run to completion; k >= 0: drop the winner's request after k enabled clocks.
   task automatic episode(input logic [3:0] m, input logic [3:0] c, input int k, input bit wdog);
      int   w, len, n, t;
      bit   idle;
      exp_t e;
      w   = pick(m, ptr);
      len = (c == 0) ? 128 : 8 * int'(c);
      if (wdog) begin
`ifdef COUNTER_ARB_WDOG_EN
         e = '{w, 16, 1'b1};
         model_err = 1;
`else
         e = '{w, k, 1'b1};
`endif
      end else e = (k >= 0) ? '{w, k, 1'b1} : '{w, len, 1'b0};
      sb.push_back(e);
      ptr  = (w + 1) % 4;
      idle = !busy;
      req    = m;
      cycles = c;
      t = 0;
      while (gnt == 0 && t < 4) begin
         @(negedge clk);
         t++;
      end
      if (gnt == 0) begin
         cmp++;
         bad++;
         $display("FAIL grant_timeout: gnt=%b after %0d clks, expected a grant", gnt, t);
         return;
      end
      if (idle) check("gnt_latency", t, 1);
      n = 0;
      for (int b = 0; b < 400 && gnt != 0; b++) begin
         if (cnt_ce) n++;
         if (n == k) req[w] = 1'b0;
         else if (k < 0 || n < k) begin
            req    = 4'($urandom) | (4'b1 << w);
            cycles = 4'($urandom);
         end
         @(negedge clk);
      end
      if (gnt != 0) begin
         cmp++;
         bad++;
         $display("FAIL episode_timeout: gnt=%b still set, expected release", gnt);
      end
   endtask

   initial begin
      int len, k;
      logic [3:0] m, c;
      do_reset();
      episode(4'b0001, 4'd2, -1, 0);
      req    = 4'b0001;
      cycles = 4'd4;
      sb.push_back('{0, 0, 1'b1});
      repeat (6) @(negedge clk);
      #2 rst = 0;
      #1 check_idle("midrst");
      do_reset();
      repeat (5) episode(4'b1111, 4'd1, -1, 0);
      episode(4'b0100, 4'd3, 10, 0);
      episode(4'b1111, 4'd1, -1, 0);
      episode(4'b0001, 4'd0, -1, 0);
      ov_kill = 1;
      episode(4'b0001, 4'd1, 40, 1);
      ov_kill = 0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         m   = 4'($urandom_range(1, 15));
         c   = 4'($urandom_range(0, 15));
         len = (c == 0) ? 128 : 8 * int'(c);
         k   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
         episode(m, c, k, 0);
      end
      req = '0;
      repeat (5) @(negedge clk);
      check("sb_drain", sb.size(), 0);
      check("final_busy", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "global timeout");
   end
endmodule
